// File: rtl/lu_row_store.sv
// lu_row_store: SIZE x SIZE complex matrix row store for the LU engine.
// The host streams SIZE rows in (LOAD), the engine reads and writes rows
// in place (SERVE), then the host streams SIZE rows back out (UNLOAD).
// Optional macro LU_ROW_STORE_RAW_BYPASS_EN: a same-cycle read and accepted
// write to one address returns the written row (write-first). Without the
// macro the read returns the pre-write contents (read-first).
module lu_row_store #(
   parameter  int unsigned SIZE  = 4,
   parameter  int unsigned WIDTH = 64,
   localparam int unsigned ROW_W = SIZE * 2 * WIDTH,
   localparam int unsigned AW    = $clog2(SIZE)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_start_i,
   input  logic [ROW_W-1:0] host_in_row_i,
   input  logic             host_in_valid_i,
   output logic             host_in_ready_o,
   output logic             loaded_o,
   input  logic             compute_done_i,
   output logic [ROW_W-1:0] host_out_row_o,
   output logic [AW-1:0]    host_out_addr_o,
   output logic             host_out_valid_o,
   input  logic             host_out_ready_i,
   input  logic [AW-1:0]    rd_addr_i,
   input  logic             rd_valid_i,
   output logic [ROW_W-1:0] rd_row_o,
   output logic [AW-1:0]    rd_addr_o,
   output logic             rd_row_valid_o,
   input  logic [ROW_W-1:0] wr_row_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic             flush_i,
   output logic             busy_o
);

   typedef enum logic [1:0] {IDLE, LOAD, SERVE, UNLOAD} state_t;

   localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             load_we, eng_we, rd_req;
   logic [ROW_W-1:0] mem [SIZE];
   logic [ROW_W-1:0] rd_row_q;
   logic [AW-1:0]    rd_addr_q;
   logic             rd_valid_q;

   // State and row counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and memory write enables; flush overrides everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_we = 1'b0;
      eng_we  = 1'b0;
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (load_start_i) begin
                  state_d = LOAD;
                  cnt_d   = '0;
               end
            end
            LOAD: begin
               if (host_in_valid_i) begin
                  load_we = 1'b1;
                  if (cnt_q == LAST) begin
                     state_d = SERVE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            SERVE: begin
               eng_we = wr_valid_i;
               if (compute_done_i) begin
                  state_d = UNLOAD;
                  cnt_d   = '0;
               end
            end
            UNLOAD: begin
               if (host_out_ready_i) begin
                  if (cnt_q == LAST) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Row memory: host load port and engine writeback port never overlap in time
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < SIZE; i++) mem[AW'(i)] <= '0;
      end else begin
         if (load_we) mem[cnt_q] <= host_in_row_i;
         if (eng_we)  mem[wr_addr_i] <= wr_row_i;
      end
   end

   assign rd_req = rd_valid_i && (state_q == SERVE) && !flush_i;

   // One-cycle read pipeline; data and address hold when no request is issued
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_valid_q <= 1'b0;
         rd_row_q   <= '0;
         rd_addr_q  <= '0;
      end else begin
         rd_valid_q <= rd_req;
         if (rd_req) begin
            rd_addr_q <= rd_addr_i;
`ifdef LU_ROW_STORE_RAW_BYPASS_EN
            rd_row_q  <= (eng_we && (wr_addr_i == rd_addr_i)) ? wr_row_i : mem[rd_addr_i];
`else
            rd_row_q  <= mem[rd_addr_i];
`endif
         end
      end
   end

   assign rd_row_o         = rd_row_q;
   assign rd_addr_o        = rd_addr_q;
   assign rd_row_valid_o   = rd_valid_q;
   assign host_in_ready_o  = (state_q == LOAD);
   assign loaded_o         = (state_q == SERVE);
   assign wr_ready_o       = (state_q == SERVE);
   assign busy_o           = (state_q != IDLE);
   assign host_out_valid_o = (state_q == UNLOAD);
   // Unload data comes straight from registers, so it holds while the host stalls
   assign host_out_row_o   = (state_q == UNLOAD) ? mem[cnt_q] : '0;
   assign host_out_addr_o  = (state_q == UNLOAD) ? cnt_q : '0;

endmodule

// File: tb/tb_lu_row_store.sv
// Self-checking bench for lu_row_store: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_lu_row_store;

   localparam int unsigned SIZE  = 4;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned ROW_W = SIZE * 2 * WIDTH;
   localparam int unsigned AW    = $clog2(SIZE);
`ifdef LU_ROW_STORE_RAW_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load_start = 1'b0;
   logic [ROW_W-1:0] host_in_row = '0;
   logic             host_in_valid = 1'b0;
   logic             host_in_ready;
   logic             loaded;
   logic             compute_done = 1'b0;
   logic [ROW_W-1:0] host_out_row;
   logic [AW-1:0]    host_out_addr;
   logic             host_out_valid;
   logic             host_out_ready = 1'b0;
   logic [AW-1:0]    rd_addr = '0;
   logic             rd_valid = 1'b0;
   logic [ROW_W-1:0] rd_row;
   logic [AW-1:0]    rd_addr_echo;
   logic             rd_row_valid;
   logic [ROW_W-1:0] wr_row = '0;
   logic [AW-1:0]    wr_addr = '0;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic             flush = 1'b0;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lu_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .load_start_i    (load_start),
      .host_in_row_i   (host_in_row),
      .host_in_valid_i (host_in_valid),
      .host_in_ready_o (host_in_ready),
      .loaded_o        (loaded),
      .compute_done_i  (compute_done),
      .host_out_row_o  (host_out_row),
      .host_out_addr_o (host_out_addr),
      .host_out_valid_o(host_out_valid),
      .host_out_ready_i(host_out_ready),
      .rd_addr_i       (rd_addr),
      .rd_valid_i      (rd_valid),
      .rd_row_o        (rd_row),
      .rd_addr_o       (rd_addr_echo),
      .rd_row_valid_o  (rd_row_valid),
      .wr_row_i        (wr_row),
      .wr_addr_i       (wr_addr),
      .wr_valid_i      (wr_valid),
      .wr_ready_o      (wr_ready),
      .flush_i         (flush),
      .busy_o          (busy)
   );

   task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [ROW_W-1:0] rep(input logic [7:0] b);
      logic [ROW_W-1:0] r;
      r = {(ROW_W/8){b}};
      return r;
   endfunction

   function automatic logic [ROW_W-1:0] rnd_row();
      logic [ROW_W-1:0] r;
      for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_LOAD = 1, M_SERVE = 2, M_UNLOAD = 3;
   int               m_phase;
   logic [AW-1:0]    m_idx;
   logic [ROW_W-1:0] m_mem [SIZE];
   logic             m_rdv;
   logic [ROW_W-1:0] m_rdrow;
   logic [AW-1:0]    m_rdaddr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  <= M_IDLE;
         m_idx    <= '0;
         m_rdv    <= 1'b0;
         m_rdrow  <= '0;
         m_rdaddr <= '0;
         for (int i = 0; i < SIZE; i++) m_mem[AW'(i)] <= '0;
      end else begin
         m_rdv <= 1'b0;
         if (flush) begin
            m_phase <= M_IDLE;
            m_idx   <= '0;
         end else if (m_phase == M_IDLE) begin
            if (load_start) begin
               m_phase <= M_LOAD;
               m_idx   <= '0;
            end
         end else if (m_phase == M_LOAD) begin
            if (host_in_valid) begin
               m_mem[m_idx] <= host_in_row;
               if (int'(m_idx) == SIZE - 1) begin
                  m_phase <= M_SERVE;
                  m_idx   <= '0;
               end else m_idx <= m_idx + 1'b1;
            end
         end else if (m_phase == M_SERVE) begin
            if (rd_valid) begin
               m_rdv    <= 1'b1;
               m_rdaddr <= rd_addr;
               m_rdrow  <= (BYPASS && wr_valid && wr_addr == rd_addr) ? wr_row : m_mem[rd_addr];
            end
            if (wr_valid) m_mem[wr_addr] <= wr_row;
            if (compute_done) begin
               m_phase <= M_UNLOAD;
               m_idx   <= '0;
            end
         end else begin
            if (host_out_ready) begin
               if (int'(m_idx) == SIZE - 1) begin
                  m_phase <= M_IDLE;
                  m_idx   <= '0;
               end else m_idx <= m_idx + 1'b1;
            end
         end
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      chk("host_in_ready", ROW_W'(host_in_ready), ROW_W'(m_phase == M_LOAD));
      chk("loaded", ROW_W'(loaded), ROW_W'(m_phase == M_SERVE));
      chk("wr_ready", ROW_W'(wr_ready), ROW_W'(m_phase == M_SERVE));
      chk("busy", ROW_W'(busy), ROW_W'(m_phase != M_IDLE));
      chk("host_out_valid", ROW_W'(host_out_valid), ROW_W'(m_phase == M_UNLOAD));
      chk("rd_row_valid", ROW_W'(rd_row_valid), ROW_W'(m_rdv));
      if (m_phase == M_UNLOAD) begin
         chk("host_out_addr", ROW_W'(host_out_addr), ROW_W'(m_idx));
         chk("host_out_row", host_out_row, m_mem[m_idx]);
      end
      if (m_rdv) begin
         chk("rd_addr_o", ROW_W'(rd_addr_echo), ROW_W'(m_rdaddr));
         chk("rd_row", rd_row, m_rdrow);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_start = 1'b0; host_in_valid = 1'b0; compute_done = 1'b0;
      host_out_ready = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_host_in_ready"}, ROW_W'(host_in_ready), '0);
      chk({tag, "_loaded"}, ROW_W'(loaded), '0);
      chk({tag, "_host_out_valid"}, ROW_W'(host_out_valid), '0);
      chk({tag, "_host_out_row"}, host_out_row, '0);
      chk({tag, "_host_out_addr"}, ROW_W'(host_out_addr), '0);
      chk({tag, "_rd_row"}, rd_row, '0);
      chk({tag, "_rd_addr"}, ROW_W'(rd_addr_echo), '0);
      chk({tag, "_rd_row_valid"}, ROW_W'(rd_row_valid), '0);
      chk({tag, "_wr_ready"}, ROW_W'(wr_ready), '0);
      chk({tag, "_busy"}, ROW_W'(busy), '0);
   endtask

   task automatic load_rows(input logic [ROW_W-1:0] r0, input logic [ROW_W-1:0] r1,
                            input logic [ROW_W-1:0] r2, input logic [ROW_W-1:0] r3);
      logic [ROW_W-1:0] rows [4];
      rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("load_ready", ROW_W'(host_in_ready), ROW_W'(1));
      for (int r = 0; r < 4; r++) begin
         host_in_valid = 1'b1; host_in_row = rows[r]; tick();
      end
      host_in_valid = 1'b0;
      chk("loaded_after_4", ROW_W'(loaded), ROW_W'(1));
   endtask

   task automatic read_lit(input logic [AW-1:0] a, input logic [ROW_W-1:0] exp, input string name);
      rd_valid = 1'b1; rd_addr = a; tick(); rd_valid = 1'b0;
      chk({name, "_v"}, ROW_W'(rd_row_valid), ROW_W'(1));
      chk({name, "_a"}, ROW_W'(rd_addr_echo), ROW_W'(a));
      chk(name, rd_row, exp);
   endtask

   initial begin
      logic [ROW_W-1:0] coll_exp;
      int guard;
      idle_inputs();
      #1;
      check_all_zero("rst0");
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check_all_zero("idle");

      // Load and serve
      load_rows(rep(8'h11), rep(8'h22), rep(8'h33), rep(8'h44));
      // Pipelined reads 2,0,3
      rd_valid = 1'b1; rd_addr = 2; tick();
      chk("rd2_v", ROW_W'(rd_row_valid), ROW_W'(1));
      chk("rd2_a", ROW_W'(rd_addr_echo), ROW_W'(2));
      chk("rd2", rd_row, rep(8'h33));
      rd_addr = 0; tick();
      chk("rd0", rd_row, rep(8'h11));
      rd_addr = 3; tick();
      chk("rd3_a", ROW_W'(rd_addr_echo), ROW_W'(3));
      chk("rd3", rd_row, rep(8'h44));
      rd_valid = 1'b0; tick();
      chk("rd_idle_v", ROW_W'(rd_row_valid), '0);
      // Writeback
      wr_valid = 1'b1; wr_addr = 1; wr_row = rep(8'hAA); tick(); wr_valid = 1'b0;
      read_lit(1, rep(8'hAA), "rd_after_wr");
      // Collision
      coll_exp = BYPASS ? rep(8'hBB) : rep(8'h44);
      wr_valid = 1'b1; wr_addr = 3; wr_row = rep(8'hBB);
      rd_valid = 1'b1; rd_addr = 3; tick();
      wr_valid = 1'b0; rd_valid = 1'b0;
      chk("collision", rd_row, coll_exp);
      read_lit(3, rep(8'hBB), "after_collision");
      // Unload with read in the compute_done cycle
      compute_done = 1'b1; rd_valid = 1'b1; rd_addr = 2; host_out_ready = 1'b1; tick();
      compute_done = 1'b0; rd_valid = 1'b0;
      chk("rd_at_done", rd_row, rep(8'h33));
      chk("out0", host_out_row, rep(8'h11)); tick();
      chk("out1_a", ROW_W'(host_out_addr), ROW_W'(1));
      chk("out1", host_out_row, rep(8'hAA)); tick();
      chk("out2", host_out_row, rep(8'h33)); tick();
      chk("out3", host_out_row, rep(8'hBB)); tick();
      chk("unload_busy", ROW_W'(busy), '0);
      chk("unload_valid", ROW_W'(host_out_valid), '0);
      host_out_ready = 1'b0;

      // Writes outside SERVE are ignored
      wr_valid = 1'b1; wr_addr = 0; wr_row = rep(8'hEE); rd_valid = 1'b1; tick();
      idle_inputs();
      chk("idle_no_rd", ROW_W'(rd_row_valid), '0);

      // Randomized rounds
      for (int round = 0; round < 3; round++) begin
         load_start = 1'b1; tick(); load_start = 1'b0;
         guard = 0;
         while (m_phase == M_LOAD && guard < 200) begin
            host_in_valid = ($urandom_range(0, 3) != 0);
            host_in_row = rnd_row();
            tick(); guard++;
         end
         host_in_valid = 1'b0;
         if (guard >= 200) chk("load_timeout", ROW_W'(1), '0);
         for (int c = 0; c < 150; c++) begin
            rd_valid = $urandom_range(0, 1); rd_addr = AW'($urandom_range(0, SIZE - 1));
            wr_valid = $urandom_range(0, 1); wr_addr = AW'($urandom_range(0, SIZE - 1));
            wr_row = rnd_row();
            if ($urandom_range(0, 7) == 0) wr_addr = rd_addr;
            tick();
         end
         rd_valid = 1'b0; wr_valid = 1'b0;
         compute_done = 1'b1; tick(); compute_done = 1'b0;
         guard = 0;
         while (m_phase == M_UNLOAD && guard < 200) begin
            host_out_ready = $urandom_range(0, 1);
            tick(); guard++;
         end
         host_out_ready = 1'b0;
         if (guard >= 200) chk("unload_timeout", ROW_W'(1), '0);
         tick();
      end

      // Backpressure then flush during unload
      load_rows(rep(8'h55), rep(8'h66), rep(8'h77), rep(8'h88));
      compute_done = 1'b1; tick(); compute_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("stall_row0", host_out_row, rep(8'h55));
         chk("stall_addr0", ROW_W'(host_out_addr), '0);
         tick();
      end
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_busy", ROW_W'(busy), '0);
      chk("flush_out_valid", ROW_W'(host_out_valid), '0);
      // New load after flush, then flush with a read in the same cycle
      load_rows(rep(8'h99), rep(8'h5A), rep(8'hA5), rep(8'hC3));
      read_lit(2, rep(8'hA5), "reload_rd2");
      rd_valid = 1'b1; rd_addr = 1; flush = 1'b1; tick();
      idle_inputs();
      chk("flush_drop_rd", ROW_W'(rd_row_valid), '0);
      chk("flush2_busy", ROW_W'(busy), '0);
      tick();

      // Async reset in the middle of LOAD
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int r = 0; r < 2; r++) begin
         host_in_valid = 1'b1; host_in_row = rnd_row(); tick();
      end
      host_in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      check_all_zero("post_rst");
      load_rows(rep(8'h01), rep(8'h02), rep(8'h03), rep(8'h04));
      compute_done = 1'b1; host_out_ready = 1'b1; tick(); compute_done = 1'b0;
      repeat (4) tick();
      idle_inputs();
      chk("final_busy", ROW_W'(busy), '0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lu_row_store.md
Name: lu_row_store

Overview:
- Matrix row store that answers the LU engine's row-memory interface.
- Returns requested rows one cycle after each read request and accepts row writebacks from the engine.
- Also holds a host-side load/unload sequencer: the host streams SIZE rows in, the engine computes in place, then the host streams SIZE rows out.
- Sits between the host/DMA and the lu engine; replaces the behavioural row memory used in simulation.

Parameters:
- SIZE, 4, matrix dimension (rows, and complex elements per row).
- WIDTH, 64, bits per real or imaginary part.
- Derived: ROW_W = SIZE*2*WIDTH; element j occupies {imag,real} at bits [j*2*WIDTH +: 2*WIDTH]; AW = $clog2(SIZE).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- load_start_i  in  1  pulse; begin host load
- host_in_row_i  in  ROW_W  row from host
- host_in_valid_i  in  1  host row valid
- host_in_ready_o  out  1  store accepts host row
- loaded_o  out  1  all SIZE rows loaded; engine may start
- compute_done_i  in  1  pulse; engine finished, begin unload
- host_out_row_o  out  ROW_W  row to host
- host_out_addr_o  out  AW  index of host_out_row_o
- host_out_valid_o  out  1  host output valid
- host_out_ready_i  in  1  host accepts output row
- rd_addr_i  in  AW  engine read address
- rd_valid_i  in  1  engine read request
- rd_row_o  out  ROW_W  read data
- rd_addr_o  out  AW  address echoed with read data
- rd_row_valid_o  out  1  read data valid
- wr_row_i  in  ROW_W  engine writeback row
- wr_addr_i  in  AW  writeback address
- wr_valid_i  in  1  writeback valid
- wr_ready_o  out  1  store accepts writeback
- flush_i  in  1  synchronous abort to IDLE
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, row counter=0, memory cleared to 0.
  - All outputs 0: host_in_ready_o, loaded_o, host_out_valid_o, host_out_row_o, host_out_addr_o, rd_row_o, rd_addr_o, rd_row_valid_o, wr_ready_o, busy_o.
  - Reset mid-operation discards the transfer in progress.
- States: IDLE, LOAD, SERVE, UNLOAD.
- IDLE:
  - load_start_i -> LOAD, counter=0. All other inputs ignored.
- LOAD:
  - host_in_ready_o=1.
  - Each host_in_valid_i writes mem[counter] and increments counter.
  - On the SIZE-th accepted row: -> SERVE, counter=0.
- SERVE:
  - loaded_o=1 and wr_ready_o=1.
  - Read: a request in cycle N produces rd_row_valid_o=1, rd_row_o=mem[rd_addr_i] and rd_addr_o=rd_addr_i in cycle N+1. One request per cycle, fully pipelined, no backpressure on reads.
  - Write: wr_valid_i & wr_ready_o writes mem[wr_addr_i] at the clock edge.
  - compute_done_i -> UNLOAD, counter=0. A read issued in the same cycle still returns its data in the next cycle.
- UNLOAD:
  - host_out_valid_o=1, host_out_row_o=mem[counter], host_out_addr_o=counter.
  - Output is registered and stable while host_out_ready_i=0.
  - The counter advances on host_out_valid_o & host_out_ready_i.
  - After row SIZE-1 is accepted: -> IDLE, host_out_valid_o=0 in the next cycle.
- Outside SERVE: rd_valid_i produces no response; wr_ready_o=0, so writes are not accepted.
- rd_row_valid_o is registered from (rd_valid_i & state==SERVE).
- Same-cycle read and write to the same address: see Optional Feature.
- Writes to different addresses are independent.
- flush_i (priority over every other input except reset):
  - Next state IDLE, counter=0, all valids cleared next cycle.
  - Memory contents retained.
  - A read issued in the flush cycle is dropped.
- Address range: SIZE must be a power of two, so AW covers exactly SIZE rows and addresses never exceed the row count.

Optional Feature:
- Macro LU_ROW_STORE_RAW_BYPASS_EN.
- Defined: a read and an accepted write to the same address in the same cycle return wr_row_i on rd_row_o in the next cycle (write-first).
- Undefined: the read returns the pre-write contents (read-first); the write still completes.

Test Plan:
- Load and unload: load_start_i, rows 0..3 = 0x11.., 0x22.., 0x33.., 0x44.. with host_in_valid_i continuous, then compute_done_i, host_out_ready_i=1 -> loaded_o rises the cycle after the 4th row; unload yields addr 0..3 with matching data; busy_o=0 afterwards.
- Read latency: in SERVE, rd_valid_i with addr 2,0,3 on consecutive cycles -> rd_row_valid_o on the 3 following cycles, rd_addr_o 2,0,3, with the matching rows.
- Writeback: write row 0xAA.. to addr 1, then read addr 1 -> 0xAA..; unload then shows row 1 = 0xAA...
- Collision: same-cycle write 0xBB.. and read, both addr 3 -> 0x44.. without the macro, 0xBB.. with it; mem[3]=0xBB.. in both builds.
- Backpressure and flush: during unload, hold host_out_ready_i=0 for 5 cycles -> row 0 stable; assert flush_i -> IDLE next cycle with valids 0, then a new load succeeds.
- Async reset: assert rst_ni=0 in the middle of LOAD after 2 rows -> all outputs 0 immediately and state IDLE.
